// File: rtl/tri_project_seq.sv
// Projects one triangle's three camera-space vertices to screen space with a
// single time-shared multiplier, then derives a clamped integer pixel bounding box.
module tri_project_seq #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [287:0] in_vtx,
  input  logic [31:0]  in_f,
  input  logic [31:0]  in_cx,
  input  logic [31:0]  in_cy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [191:0] out_pts,
  output logic [15:0]  out_min_x,
  output logic [15:0]  out_min_y,
  output logic [15:0]  out_max_x,
  output logic [15:0]  out_max_y,
  output logic         out_offscreen
);

  localparam logic signed [32:0] X_HI = 33'(SCREEN_W - 1);
  localparam logic signed [32:0] Y_HI = 33'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_FX = 3'd1,
    MUL_W  = 3'd2,
    BBOX   = 3'd3,
    EMIT   = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t      state_r;
  logic [31:0] vx_r [3];
  logic [31:0] vy_r [3];
  logic [31:0] vz_r [3];
  logic [31:0] px_r [3];
  logic [31:0] py_r [3];
  logic [31:0] f_r, cx_r, cy_r;
  logic [63:0] fx_r;
  logic [2:0]  coord_r;

  logic [31:0] coord_s, zinv_s, mul_b_s, proj_s;
  logic [63:0] mul_a_s, product_s;
  logic signed [31:0] mnx_s, mxx_s, mny_s, mxy_s;
  logic signed [32:0] lo_x_s, hi_x_s, lo_y_s, hi_y_s;

  function automatic logic signed [31:0] min3(input logic signed [31:0] a, b, c);
    logic signed [31:0] m;
    m = (a < b) ? a : b;
    m = (c < m) ? c : m;
    return m;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] a, b, c);
    logic signed [31:0] m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return m;
  endfunction

  function automatic logic [15:0] clamp_pix(input logic signed [32:0] v, input logic signed [32:0] hi);
    logic [15:0] r;
    if (v < 33'sd0) r = 16'd0;
    else if (v > hi) r = hi[15:0];
    else r = v[15:0];
    return r;
  endfunction

  assign in_ready = (state_r == IDLE);
  assign out_pts  = {px_r[2], py_r[2], px_r[1], py_r[1], px_r[0], py_r[0]};

  // Operand steering for the shared multiplier; only the low 64 product bits are ever consumed
  always_comb begin
    coord_s = 32'd0;
    zinv_s  = 32'd0;
    case (coord_r)
      3'd0:    begin coord_s = vx_r[0]; zinv_s = vz_r[0]; end
      3'd1:    begin coord_s = vy_r[0]; zinv_s = vz_r[0]; end
      3'd2:    begin coord_s = vx_r[1]; zinv_s = vz_r[1]; end
      3'd3:    begin coord_s = vy_r[1]; zinv_s = vz_r[1]; end
      3'd4:    begin coord_s = vx_r[2]; zinv_s = vz_r[2]; end
      3'd5:    begin coord_s = vy_r[2]; zinv_s = vz_r[2]; end
      default: begin coord_s = 32'd0;   zinv_s = 32'd0;   end
    endcase
    if (state_r == MUL_W) begin
      mul_a_s = fx_r;
      mul_b_s = zinv_s;
    end else begin
      mul_a_s = {{32{f_r[31]}}, f_r};
      mul_b_s = coord_s;
    end
    product_s = mul_a_s * {{32{mul_b_s[31]}}, mul_b_s};
    if (coord_r[0]) proj_s = product_s[63:32] + cy_r;
    else proj_s = product_s[63:32] + cx_r;
  end

  // Bounding box: floor of minima, ceil of maxima, widened so the ceil cannot wrap
  always_comb begin
    mnx_s  = min3(px_r[0], px_r[1], px_r[2]);
    mxx_s  = max3(px_r[0], px_r[1], px_r[2]);
    mny_s  = min3(py_r[0], py_r[1], py_r[2]);
    mxy_s  = max3(py_r[0], py_r[1], py_r[2]);
    lo_x_s = $signed({mnx_s[31], mnx_s}) >>> 5'd16;
    hi_x_s = ($signed({mxx_s[31], mxx_s}) + 33'sd65535) >>> 5'd16;
    lo_y_s = $signed({mny_s[31], mny_s}) >>> 5'd16;
    hi_y_s = ($signed({mxy_s[31], mxy_s}) + 33'sd65535) >>> 5'd16;
  end

  // Sequencer and all registered state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      coord_r       <= 3'd0;
      fx_r          <= 64'd0;
      f_r           <= 32'd0;
      cx_r          <= 32'd0;
      cy_r          <= 32'd0;
      out_valid     <= 1'b0;
      out_offscreen <= 1'b0;
      out_min_x     <= 16'd0;
      out_min_y     <= 16'd0;
      out_max_x     <= 16'd0;
      out_max_y     <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        vx_r[i] <= 32'd0;
        vy_r[i] <= 32'd0;
        vz_r[i] <= 32'd0;
        px_r[i] <= 32'd0;
        py_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
              vx_r[i] <= in_vtx[96*i+64 +: 32];
              vy_r[i] <= in_vtx[96*i+32 +: 32];
              vz_r[i] <= in_vtx[96*i +: 32];
            end
            f_r     <= in_f;
            cx_r    <= in_cx;
            cy_r    <= in_cy;
            coord_r <= 3'd0;
            state_r <= MUL_FX;
          end
        end
        MUL_FX: begin
          fx_r    <= product_s;
          state_r <= MUL_W;
        end
        MUL_W: begin
          case (coord_r)
            3'd0:    px_r[0] <= proj_s;
            3'd1:    py_r[0] <= proj_s;
            3'd2:    px_r[1] <= proj_s;
            3'd3:    py_r[1] <= proj_s;
            3'd4:    px_r[2] <= proj_s;
            3'd5:    py_r[2] <= proj_s;
            default: begin end
          endcase
          if (coord_r == 3'd5) begin
            state_r <= BBOX;
          end else begin
            coord_r <= coord_r + 3'd1;
            state_r <= MUL_FX;
          end
        end
        BBOX: begin
          out_min_x     <= clamp_pix(lo_x_s, X_HI);
          out_max_x     <= clamp_pix(hi_x_s, X_HI);
          out_min_y     <= clamp_pix(lo_y_s, Y_HI);
          out_max_y     <= clamp_pix(hi_y_s, Y_HI);
          out_offscreen <= (hi_x_s < 33'sd0) || (lo_x_s > X_HI) ||
                           (hi_y_s < 33'sd0) || (lo_y_s > Y_HI);
          state_r       <= EMIT;
        end
        EMIT: begin
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_project_seq.sv
// Directed and randomized checks of tri_project_seq against an arithmetic
// reference model of the projection and bounding-box rules.
module tb_tri_project_seq;

  localparam int W = 160;
  localparam int H = 120;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_offscreen;
  logic [287:0] in_vtx;
  logic [31:0]  in_f, in_cx, in_cy;
  logic [191:0] out_pts;
  logic [15:0]  out_min_x, out_min_y, out_max_x, out_max_y;

  tri_project_seq #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vtx(in_vtx), .in_f(in_f), .in_cx(in_cx), .in_cy(in_cy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pts(out_pts),
    .out_min_x(out_min_x), .out_min_y(out_min_y), .out_max_x(out_max_x),
    .out_max_y(out_max_y), .out_offscreen(out_offscreen)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0]  tv_x [3];
  logic [31:0]  tv_y [3];
  logic [31:0]  tv_z [3];
  logic [31:0]  t_f, t_cx, t_cy;
  logic [191:0] exp_pts;
  logic [15:0]  exp_mnx, exp_mny, exp_mxx, exp_mxy;
  logic         exp_off;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fxp(input int whole);
    return 32'(whole * 65536);
  endfunction

  function automatic logic [191:0] pk(input logic [31:0] x0, y0, x1, y1, x2, y2);
    return {x2, y2, x1, y1, x0, y0};
  endfunction

  // exact f*c*z_inv in 128 bits, scale back by 2^32, keep 32 bits, add centre
  function automatic logic [31:0] m_proj(input logic [31:0] f, c, zi, ctr);
    logic signed [127:0] a, b, z, w;
    a = 128'($signed(f));
    b = 128'($signed(c));
    z = 128'($signed(zi));
    w = (a * b * z) >>> 32;
    return w[31:0] + ctr;
  endfunction

  function automatic longint floor16(input longint v);
    longint q;
    q = v / 65536;
    if ((v % 65536) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint ceil16(input longint v);
    longint q;
    q = v / 65536;
    if ((v % 65536) != 0 && v > 0) q = q + 1;
    return q;
  endfunction

  function automatic logic [15:0] clampv(input longint v, input longint hi);
    if (v < 0) return 16'd0;
    if (v > hi) return 16'(hi);
    return 16'(v);
  endfunction

  task automatic set_v(input int i, input logic [31:0] x, y, z);
    tv_x[i] = x;
    tv_y[i] = y;
    tv_z[i] = z;
  endtask

  task automatic compute_model();
    longint xs [3];
    longint ys [3];
    longint mnx, mxx, mny, mxy, lox, hix, loy, hiy;
    logic [31:0] px, py;
    for (int i = 0; i < 3; i++) begin
      px = m_proj(t_f, tv_x[i], tv_z[i], t_cx);
      py = m_proj(t_f, tv_y[i], tv_z[i], t_cy);
      exp_pts[64*i+32 +: 32] = px;
      exp_pts[64*i +: 32]    = py;
      xs[i] = longint'($signed(px));
      ys[i] = longint'($signed(py));
    end
    mnx = xs[0]; mxx = xs[0]; mny = ys[0]; mxy = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < mnx) mnx = xs[i];
      if (xs[i] > mxx) mxx = xs[i];
      if (ys[i] < mny) mny = ys[i];
      if (ys[i] > mxy) mxy = ys[i];
    end
    lox = floor16(mnx); hix = ceil16(mxx);
    loy = floor16(mny); hiy = ceil16(mxy);
    exp_mnx = clampv(lox, W - 1);
    exp_mxx = clampv(hix, W - 1);
    exp_mny = clampv(loy, H - 1);
    exp_mxy = clampv(hiy, H - 1);
    exp_off = (hix < 0) || (lox > W - 1) || (hiy < 0) || (loy > H - 1);
  endtask

  task automatic drive_inputs();
    in_vtx = '0;
    for (int i = 0; i < 3; i++) begin
      in_vtx[96*i+64 +: 32] = tv_x[i];
      in_vtx[96*i+32 +: 32] = tv_y[i];
      in_vtx[96*i +: 32]    = tv_z[i];
    end
    in_f  = t_f;
    in_cx = t_cx;
    in_cy = t_cy;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " valid"}, 192'(out_valid), 192'(1'b1));
    chk({tag, " pts"}, out_pts, exp_pts);
    chk({tag, " min_x"}, 192'(out_min_x), 192'(exp_mnx));
    chk({tag, " max_x"}, 192'(out_max_x), 192'(exp_mxx));
    chk({tag, " min_y"}, 192'(out_min_y), 192'(exp_mny));
    chk({tag, " max_y"}, 192'(out_max_y), 192'(exp_mxy));
    chk({tag, " offscreen"}, 192'(out_offscreen), 192'(exp_off));
  endtask

  // called #1 after the accepting edge; leaves the bench at a negedge with out_valid high
  task automatic wait_result(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, " latency"}, 192'(n), 192'(14));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic start_tri(input string tag);
    compute_model();
    @(negedge clk);
    chk({tag, " in_ready idle"}, 192'(in_ready), 192'(1'b1));
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(tag);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " valid drop"}, 192'(out_valid), 192'(1'b0));
    chk({tag, " ready back"}, 192'(in_ready), 192'(1'b1));
  endtask

  function automatic logic [31:0] rnd_coord();
    return $urandom_range(32'd26214400) - 32'd13107200;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_vtx = {9{$urandom}}; in_f = $urandom; in_cx = $urandom; in_cy = $urandom;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("rst in_ready", 192'(in_ready), 192'(1'b1));
    chk("rst out_valid", 192'(out_valid), 192'(1'b0));
    chk("rst offscreen", 192'(out_offscreen), 192'(1'b0));
    chk("rst pts", out_pts, 192'd0);
    chk("rst bbox", 192'({out_min_x, out_min_y, out_max_x, out_max_y}), 192'd0);

    t_f = fxp(1); t_cx = 32'd0; t_cy = 32'd0;
    set_v(0, fxp(2), fxp(4), 32'h0000_8000);
    set_v(1, fxp(6), fxp(2), 32'h0000_8000);
    set_v(2, fxp(4), fxp(8), 32'h0000_4000);
    start_tri("basic");
    chk("basic pts const", out_pts, pk(fxp(1), fxp(2), fxp(3), fxp(1), fxp(1), fxp(2)));
    chk("basic bbox const", 192'({out_min_x, out_max_x, out_min_y, out_max_y}),
        192'({16'd1, 16'd3, 16'd1, 16'd2}));
    chk("basic off const", 192'(out_offscreen), 192'(1'b0));
    handoff("basic");

    set_v(0, 32'h000A_4000, 32'd0, 32'h0001_0000);
    set_v(1, 32'h0014_8000, 32'd0, 32'h0001_0000);
    set_v(2, 32'h000F_0000, 32'd0, 32'h0001_0000);
    start_tri("frac");
    chk("frac min_x const", 192'(out_min_x), 192'(10));
    chk("frac max_x const", 192'(out_max_x), 192'(21));
    handoff("frac");

    set_v(0, 32'hFFFF_8000, fxp(1), 32'h0001_0000);
    set_v(1, fxp(3), fxp(1), 32'h0001_0000);
    set_v(2, fxp(1), fxp(1), 32'h0001_0000);
    start_tri("neg");
    chk("neg min_x const", 192'(out_min_x), 192'(0));
    handoff("neg");

    set_v(0, fxp(200), fxp(10), 32'h0001_0000);
    set_v(1, fxp(250), fxp(10), 32'h0001_0000);
    set_v(2, fxp(300), fxp(10), 32'h0001_0000);
    start_tri("offs");
    chk("offs flag const", 192'(out_offscreen), 192'(1'b1));
    chk("offs x const", 192'({out_min_x, out_max_x}), 192'({16'd159, 16'd159}));
    handoff("offs");

    set_v(0, fxp(-50), fxp(5), 32'h0001_0000);
    set_v(1, fxp(0), fxp(5), 32'h0001_0000);
    set_v(2, fxp(50), fxp(5), 32'h0001_0000);
    start_tri("strad");
    chk("strad const", 192'({out_min_x, out_max_x, 15'd0, out_offscreen}),
        192'({16'd0, 16'd50, 15'd0, 1'b0}));
    handoff("strad");

    // backpressure: a second triangle is presented during the stall and must be ignored
    t_f = fxp(1); t_cx = fxp(10); t_cy = fxp(5);
    set_v(0, fxp(3), fxp(7), 32'h0001_0000);
    set_v(1, fxp(20), fxp(1), 32'h0000_8000);
    set_v(2, fxp(-4), fxp(9), 32'h0002_0000);
    start_tri("bp");
    set_v(0, fxp(40), fxp(30), 32'h0001_0000);
    set_v(1, fxp(60), fxp(35), 32'h0001_0000);
    set_v(2, fxp(50), fxp(45), 32'h0001_0000);
    drive_inputs();
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("bp hold pts", out_pts, exp_pts);
      chk("bp hold ctl", 192'({out_valid, in_ready, out_min_x, out_max_y}),
          192'({1'b1, 1'b0, exp_mnx, exp_mxy}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp idle", 192'({in_ready, out_valid}), 192'({1'b1, 1'b0}));
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp accepted", 192'(in_ready), 192'(1'b0));
    compute_model();
    wait_result("bp next");
    handoff("bp next");

    // reset in the middle of a computation
    t_f = fxp(2); t_cx = fxp(80); t_cy = fxp(60);
    set_v(0, fxp(-10), fxp(7), 32'h0000_8000);
    set_v(1, fxp(15), fxp(-3), 32'h0001_0000);
    set_v(2, fxp(5), fxp(12), 32'h0000_4000);
    @(negedge clk);
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst in_ready", 192'(in_ready), 192'(1'b1));
    chk("mrst pts", out_pts, 192'd0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("mrst no valid", 192'(out_valid), 192'(1'b0));
    end
    start_tri("mrst after");
    handoff("mrst after");

    t_f = fxp(1); t_cx = fxp(80); t_cy = fxp(60);
    for (int i = 0; i < 3; i++) set_v(i, 32'd0, 32'd0, 32'h0001_0000);
    start_tri("ctr");
    chk("ctr pts const", out_pts, pk(fxp(80), fxp(60), fxp(80), fxp(60), fxp(80), fxp(60)));
    chk("ctr bbox const", 192'({out_min_x, out_max_x, out_min_y, out_max_y}),
        192'({16'd80, 16'd80, 16'd60, 16'd60}));
    handoff("ctr");

    t_f = 32'h7FFF_0000; t_cx = 32'd0; t_cy = 32'd0;
    set_v(0, 32'h7FFF_0000, fxp(1), 32'h7FFF_0000);
    set_v(1, fxp(2), 32'h7FFF_0000, 32'h7FFF_0000);
    set_v(2, 32'h8001_0000, fxp(-3), 32'h7FFF_0000);
    start_tri("wrap");
    handoff("wrap");

    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        t_f  = $urandom_range(32'h0004_0000, 32'h0001_0000);
        t_cx = $urandom_range(32'h00A0_0000);
        t_cy = $urandom_range(32'h0078_0000);
        for (int i = 0; i < 3; i++)
          set_v(i, rnd_coord(), rnd_coord(), $urandom_range(32'h0002_0000, 32'h0000_4000));
      end else begin
        t_f = $urandom; t_cx = $urandom; t_cy = $urandom;
        for (int i = 0; i < 3; i++) set_v(i, $urandom, $urandom, $urandom);
      end
      start_tri("rand");
      handoff("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
